// File: rtl/lfsr_checker.sv
// lfsr_checker: serial checker for a 22-bit XNOR PRBS (taps 22/21).
// Fills a 22-bit history from the stream, verifies a run of correct
// predictions, then regenerates the sequence locally and counts channel
// errors. A burst of errors inside one observation window drops lock.
`timescale 1ns/1ps

module lfsr_checker #(
    parameter int LOCK_THRESH = 32,
    parameter int WINDOW      = 64,
    parameter int LOSS_THRESH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic        in_bit,
    input  logic        clear_cnt,
    output logic        locked,
    output logic        err_pulse,
    output logic [15:0] err_count,
    output logic [31:0] bit_count,
    output logic        lost_lock
);

    localparam int MW = $clog2(LOCK_THRESH + 1);
    localparam int WW = (WINDOW > 2) ? $clog2(WINDOW) : 1;
    localparam int EW = $clog2(LOSS_THRESH + 1);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // Next bit of the generator given its current 22-bit state.
    function automatic logic predict_bit(input logic [21:0] hist);
        return ~(hist[21] ^ hist[20]);
    endfunction

    state_t        state_r,     state_nx_s;
    logic [21:0]   hist_r,      hist_nx_s;
    logic [4:0]    fill_r,      fill_nx_s;
    logic [MW-1:0] match_r,     match_nx_s;
    logic [WW-1:0] win_cnt_r,   win_cnt_nx_s;
    logic [EW-1:0] win_err_r,   win_err_nx_s;
    logic [15:0]   err_count_r, err_count_nx_s;
    logic [31:0]   bit_count_r, bit_count_nx_s;
    logic          lost_lock_r, lost_lock_nx_s;
    logic          err_pulse_r, err_pulse_nx_s;
    logic          locked_r,    locked_nx_s;

    logic          pred_s;
    logic          miss_s;
    logic [21:0]   shift_in_s;
    logic [EW-1:0] win_err_sum_s;
    logic          set_lost_s;

    assign locked    = locked_r;
    assign err_pulse = err_pulse_r;
    assign err_count = err_count_r;
    assign bit_count = bit_count_r;
    assign lost_lock = lost_lock_r;

    // State register of the acquisition FSM.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_SEARCH;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state, history, counter and output computation.
    always_comb begin
        state_nx_s     = state_r;
        hist_nx_s      = hist_r;
        fill_nx_s      = fill_r;
        match_nx_s     = match_r;
        win_cnt_nx_s   = win_cnt_r;
        win_err_nx_s   = win_err_r;
        err_count_nx_s = err_count_r;
        bit_count_nx_s = bit_count_r;
        lost_lock_nx_s = lost_lock_r;
        err_pulse_nx_s = 1'b0;
        set_lost_s     = 1'b0;
        pred_s         = predict_bit(hist_r);
        miss_s         = in_bit ^ pred_s;
        shift_in_s     = {hist_r[20:0], in_bit};
        win_err_sum_s  = win_err_r + EW'(miss_s);

        if (in_valid) begin
            case (state_r)
                ST_SEARCH: begin
                    hist_nx_s = shift_in_s;
                    if (fill_r == 5'd21) begin
                        fill_nx_s  = 5'd0;
                        match_nx_s = {MW{1'b0}};
                        state_nx_s = ST_VERIFY;
                    end else begin
                        fill_nx_s = fill_r + 5'd1;
                    end
                end
                ST_VERIFY: begin
                    hist_nx_s = shift_in_s;
                    if (miss_s) begin
                        match_nx_s = {MW{1'b0}};
                    end else if (match_r == MW'(LOCK_THRESH - 1)) begin
                        match_nx_s = {MW{1'b0}};
                        // All-ones is the XNOR lock-up state: it predicts
                        // itself forever, so it must never be accepted.
                        if (shift_in_s == 22'h3FFFFF) begin
                            state_nx_s = ST_SEARCH;
                            fill_nx_s  = 5'd0;
                        end else begin
                            state_nx_s   = ST_LOCKED;
                            win_cnt_nx_s = {WW{1'b0}};
                            win_err_nx_s = {EW{1'b0}};
                        end
                    end else begin
                        match_nx_s = match_r + MW'(1);
                    end
                end
                ST_LOCKED: begin
                    // Regenerate locally so channel errors never reach the reference.
                    hist_nx_s = {hist_r[20:0], pred_s};
                    if (bit_count_r != 32'hFFFF_FFFF) begin
                        bit_count_nx_s = bit_count_r + 32'd1;
                    end else begin
                        bit_count_nx_s = bit_count_r;
                    end
                    if (miss_s) begin
                        err_pulse_nx_s = 1'b1;
                        if (err_count_r != 16'hFFFF) begin
                            err_count_nx_s = err_count_r + 16'd1;
                        end else begin
                            err_count_nx_s = err_count_r;
                        end
                    end else begin
                        err_count_nx_s = err_count_r;
                    end
                    if (win_err_sum_s == EW'(LOSS_THRESH)) begin
                        state_nx_s   = ST_SEARCH;
                        set_lost_s   = 1'b1;
                        fill_nx_s    = 5'd0;
                        match_nx_s   = {MW{1'b0}};
                        win_cnt_nx_s = {WW{1'b0}};
                        win_err_nx_s = {EW{1'b0}};
                    end else if (win_cnt_r == WW'(WINDOW - 1)) begin
                        win_cnt_nx_s = {WW{1'b0}};
                        win_err_nx_s = {EW{1'b0}};
                    end else begin
                        win_cnt_nx_s = win_cnt_r + WW'(1);
                        win_err_nx_s = win_err_sum_s;
                    end
                end
                default: begin
                    state_nx_s = ST_SEARCH;
                    fill_nx_s  = 5'd0;
                    match_nx_s = {MW{1'b0}};
                end
            endcase
        end else begin
            state_nx_s = state_r;
        end

        // A clear wins over increments, but a loss in the same cycle stays visible.
        if (clear_cnt) begin
            err_count_nx_s = 16'd0;
            bit_count_nx_s = 32'd0;
            lost_lock_nx_s = set_lost_s;
        end else if (set_lost_s) begin
            lost_lock_nx_s = 1'b1;
        end else begin
            lost_lock_nx_s = lost_lock_r;
        end

        locked_nx_s = (state_nx_s == ST_LOCKED);
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hist_r      <= 22'd0;
            fill_r      <= 5'd0;
            match_r     <= {MW{1'b0}};
            win_cnt_r   <= {WW{1'b0}};
            win_err_r   <= {EW{1'b0}};
            err_count_r <= 16'd0;
            bit_count_r <= 32'd0;
            lost_lock_r <= 1'b0;
            err_pulse_r <= 1'b0;
            locked_r    <= 1'b0;
        end else begin
            hist_r      <= hist_nx_s;
            fill_r      <= fill_nx_s;
            match_r     <= match_nx_s;
            win_cnt_r   <= win_cnt_nx_s;
            win_err_r   <= win_err_nx_s;
            err_count_r <= err_count_nx_s;
            bit_count_r <= bit_count_nx_s;
            lost_lock_r <= lost_lock_nx_s;
            err_pulse_r <= err_pulse_nx_s;
            locked_r    <= locked_nx_s;
        end
    end

endmodule

// File: doc/lfsr_checker.md
LFSR_CHECKER -- requirements
Module: lfsr_checker

Interface
REQ-001 Parameter LOCK_THRESH, default 32: consecutive correct predictions required in VERIFY before declaring lock.
REQ-002 Parameter WINDOW, default 64: length, in valid bits, of the loss-of-lock observation window.
REQ-003 Parameter LOSS_THRESH, default 8: mismatches within one WINDOW that force loss of lock.
REQ-004 clk  in  1  clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 in_valid  in  1  qualifies in_bit; the checker advances only on cycles where in_valid=1.
REQ-007 in_bit  in  1  serial stream bit, equal to the bit the 22-bit XNOR generator shifts into its LSB each step.
REQ-008 clear_cnt  in  1  synchronous clear of err_count, bit_count and lost_lock.
REQ-009 locked  out  1  high while the state is LOCKED.
REQ-010 err_pulse  out  1  one-cycle pulse per mismatched bit in LOCKED.
REQ-011 err_count  out  16  saturating count of mismatches in LOCKED.
REQ-012 bit_count  out  32  saturating count of valid bits checked in LOCKED.
REQ-013 lost_lock  out  1  sticky flag, set on the LOCKED->SEARCH transition.

Function
REQ-014 Internal 22-bit history S, with S[0] newest; prediction p = ~(S[21] ^ S[20]), which matches the generator taps 22/21 with XNOR feedback.
REQ-015 States SEARCH, VERIFY and LOCKED; all outputs registered; in_valid=0 freezes S, state and all counters.
REQ-016 SEARCH: each valid bit shifts S = {S[20:0], in_bit} and increments a 5-bit fill counter; after the 22nd valid bit, go to VERIFY with match count 0.
REQ-017 VERIFY: each valid bit is compared with p, then S shifts in in_bit.
REQ-018 VERIFY on a match: increment the match count.
REQ-019 VERIFY on a mismatch: reset the match count to 0 and stay in VERIFY.
REQ-020 VERIFY on reaching LOCK_THRESH matches: go to LOCKED, unless the post-shift S = 22'h3FFFFF (the XNOR lock-up state), in which case go to SEARCH with the fill counter at 0.
REQ-021 LOCKED: S shifts in p, not in_bit (local regeneration), so channel errors never corrupt the reference.
REQ-022 LOCKED, each valid bit: bit_count +1 (saturating at 32'hFFFFFFFF).
REQ-023 LOCKED on in_bit != p: err_pulse = 1 on the next cycle; err_count +1 (saturating at 16'hFFFF); window error count +1.
REQ-024 LOCKED window: the window bit counter wraps after WINDOW valid bits, clearing the window error count.
REQ-025 LOCKED loss of lock: when the window error count reaches LOSS_THRESH, go to SEARCH, set lost_lock and reset the fill, window and match counters to 0.
REQ-026 locked rises on the cycle after the valid bit that completes VERIFY, and falls on the cycle after the loss-triggering bit.
REQ-027 clear_cnt takes priority over a same-cycle increment: counters become 0 and lost_lock becomes 0, but err_pulse still fires for a concurrent mismatch.
REQ-028 A same-cycle lost_lock set and clear_cnt results in lost_lock = 1.
REQ-029 clear_cnt does not affect state, S or locked.
REQ-030 Counter saturation does not affect lock detection.

Reset
REQ-031 rst_n=0 at a clock edge: state = SEARCH; S, fill, match and window counters = 0.
REQ-032 rst_n=0 at a clock edge: locked = 0, err_pulse = 0, err_count = 0, bit_count = 0, lost_lock = 0.
REQ-033 Reset applies identically from any state, including mid-lock, and overrides in_valid and clear_cnt.

Verification
REQ-034 Generator seeded 22'h36473D drives in_valid=1 continuously -> locked = 1 exactly one cycle after the 54th valid bit; err_count = 0 after 10000 bits; bit_count = 9946.
REQ-035 While locked, invert one bit -> err_pulse is high for exactly one cycle, err_count = 1, locked stays 1, and the following bits produce no further errors.
REQ-036 While locked, invert 8 bits within one 64-bit window -> locked falls after the 8th error and lost_lock = 1; with the stream resumed, relock occurs 54 valid bits later.
REQ-037 Constant in_bit = 1 for 200 valid bits -> locked never asserts.
REQ-038 Mismatch coincident with clear_cnt while err_count = 5 -> err_count = 0 and err_pulse = 1.
REQ-039 in_valid toggled randomly at 50% -> lock latency counted in valid bits only, unchanged at 54.
REQ-040 rst_n pulsed low for one cycle mid-lock -> the next cycle shows all outputs 0, followed by full reacquisition.
